// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 target: byte width, default idle
// byte shifted out when nothing is queued, and the frame state encoding.
package spi_pkg;

  localparam int SPI_BITS = 8;

  localparam logic [SPI_BITS-1:0] DEFAULT_IDLE_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings one asynchronous SPI pin into the CLKOSC domain through a
// SYNC_STAGES-deep flop chain, plus a history flop that turns level changes
// into single-cycle rise/fall strobes.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic CLKOSC,
  input  logic RST,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the pin through the synchroniser and remember the previous synchronised level.
  always_ff @(posedge CLKOSC) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      hist_q <= RESET_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target (CPOL=0, CPHA=0, MSB first) for the expansion header.
// Pins are oversampled in the CLKOSC domain; received and transmitted bytes
// are exchanged with local logic through byte-wide handshakes.
module spi_target
  import spi_pkg::*;
#(
  parameter int                  SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
  input  logic                CLKOSC,
  input  logic                RST,
  input  logic                SCK,
  input  logic                MOSI,
  input  logic                CS_N,
  output logic                MISO,
  output logic                MISO_OE,
  output logic [SPI_BITS-1:0] RX_DATA,
  output logic                RX_VALID,
  input  logic                RX_ACK,
  input  logic [SPI_BITS-1:0] TX_DATA,
  input  logic                TX_LOAD,
  output logic                TX_READY,
  output logic                RX_OVERRUN,
  output logic                TX_UNDERRUN,
  output logic                FRAME_ABORT
);

  localparam int                CNT_W    = $clog2(SPI_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SPI_BITS - 1);

  // Synchronised pin views and edge strobes
  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic cs_level, cs_rise, cs_fall;

  // Level/edge outputs the protocol logic has no use for; the "unused" name keeps lint quiet
  logic unused_pin_views;
  assign unused_pin_views = ^{sck_level, mosi_rise, mosi_fall, cs_level};

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sck (
    .CLKOSC (CLKOSC),
    .RST    (RST),
    .pin    (SCK),
    .level  (sck_level),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_mosi (
    .CLKOSC (CLKOSC),
    .RST    (RST),
    .pin    (MOSI),
    .level  (mosi_level),
    .rise   (mosi_rise),
    .fall   (mosi_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
    .CLKOSC (CLKOSC),
    .RST    (RST),
    .pin    (CS_N),
    .level  (cs_level),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  // Registered state
  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_BITS-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                reload_q, reload_d;
  logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;
  logic                rx_overrun_q, rx_overrun_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic                frame_abort_q, frame_abort_d;

  // Helpers for the combinational process
  logic                start_byte;
  logic                hold_free;
  logic [SPI_BITS-1:0] rx_byte;
  logic [SPI_BITS-1:0] tx_start_byte;

  assign rx_byte       = {rx_shift_q[SPI_BITS-2:0], mosi_level};
  assign tx_start_byte = hold_full_q ? hold_q : IDLE_BYTE;

  // Next-state and datapath decisions: frame tracking, bit shifting, byte reloads and the holding register.
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    reload_d      = reload_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~RX_ACK;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    start_byte    = 1'b0;
    hold_free     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          bitcnt_d   = '0;
          reload_d   = 1'b0;
          miso_oe_d  = 1'b1;
          start_byte = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d       = ST_IDLE;
          miso_oe_d     = 1'b0;
          miso_d        = 1'b1;
          frame_abort_d = (bitcnt_q != '0);
          bitcnt_d      = '0;
          reload_d      = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d     = '0;
            rx_data_d    = rx_byte;
            rx_valid_d   = 1'b1;
            rx_overrun_d = rx_valid_q & ~RX_ACK;
            reload_d     = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end else if (sck_fall) begin
          if (reload_q) begin
            start_byte = 1'b1;
            reload_d   = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b1};
            miso_d     = tx_shift_q[SPI_BITS-2];
          end
        end
      end
    endcase

    if (start_byte) begin
      tx_shift_d    = tx_start_byte;
      miso_d        = tx_start_byte[SPI_BITS-1];
      tx_underrun_d = ~hold_full_q;
    end

    // A byte start empties the holding register before a same-cycle load is considered
    hold_free   = ~hold_full_q | start_byte;
    hold_full_d = hold_full_q & ~start_byte;
    if (TX_LOAD && hold_free) begin
      hold_d      = TX_DATA;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLKOSC) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      reload_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      reload_q      <= reload_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign MISO        = miso_q;
  assign MISO_OE     = miso_oe_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_READY    = ~hold_full_q;
  assign RX_OVERRUN  = rx_overrun_q;
  assign TX_UNDERRUN = tx_underrun_q;
  assign FRAME_ABORT = frame_abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: acts as the SPI initiator, keeps a frame-level
// reference model of the expected byte and pulse traffic, and lets two
// monitors compare what the target actually produces.
`timescale 1ns/1ps

module tb_spi_target;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;

  localparam logic [1:0] EV_RXNEW = 2'd0;
  localparam logic [1:0] EV_RXOVR = 2'd1;
  localparam logic [1:0] EV_UNDER = 2'd2;
  localparam logic [1:0] EV_ABORT = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       CLKOSC = 1'b0;
  logic       RST;
  logic       SCK;
  logic       MOSI;
  logic       CS_N;
  logic       MISO;
  logic       MISO_OE;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ACK;
  logic [7:0] TX_DATA;
  logic       TX_LOAD;
  logic       TX_READY;
  logic       RX_OVERRUN;
  logic       TX_UNDERRUN;
  logic       FRAME_ABORT;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and reference-model state
  ev_t        evQ[$];
  logic [7:0] misoQ[$];
  logic [7:0] holdQ[$];
  logic       mdlRxValid = 1'b0;
  logic [7:0] mdlRxLast  = 8'h00;
  int         mdlByteIdx;
  int         mdlFullBytes;

  spi_target #(.SYNC_STAGES(SYNC_STAGES), .IDLE_BYTE(8'hFF)) dut (
    .CLKOSC      (CLKOSC),
    .RST         (RST),
    .SCK         (SCK),
    .MOSI        (MOSI),
    .CS_N        (CS_N),
    .MISO        (MISO),
    .MISO_OE     (MISO_OE),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .RX_ACK      (RX_ACK),
    .TX_DATA     (TX_DATA),
    .TX_LOAD     (TX_LOAD),
    .TX_READY    (TX_READY),
    .RX_OVERRUN  (RX_OVERRUN),
    .TX_UNDERRUN (TX_UNDERRUN),
    .FRAME_ABORT (FRAME_ABORT)
  );

  // 100 MHz oversampling clock
  always #5 CLKOSC = ~CLKOSC;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushEvent(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    evQ.push_back(e);
  endtask

  task automatic observeEvent(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    if (evQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event actual_kind=%0d data=%0h expected=none at %0t", kind, data, $time);
    end else begin
      e = evQ.pop_front();
      checkOutput("event_kind", 32'(kind), 32'(e.kind));
      checkOutput("event_data", 32'(data), 32'(e.data));
    end
  endtask

  // Reference model: one byte starts on chip-select and after every completed byte still inside the frame.
  task automatic modelStartByte();
    logic [7:0] tx;
    if (holdQ.size() != 0) begin
      tx = holdQ.pop_front();
    end else begin
      tx = 8'hFF;
      pushEvent(EV_UNDER, 8'h00);
    end
    if (mdlByteIdx < mdlFullBytes) misoQ.push_back(tx);
    mdlByteIdx++;
  endtask

  task automatic modelRxComplete(input logic [7:0] b);
    pushEvent(mdlRxValid ? EV_RXOVR : EV_RXNEW, b);
    mdlRxValid = 1'b1;
    mdlRxLast  = b;
  endtask

  task automatic modelLoad(input logic [7:0] d);
    if (holdQ.size() == 0) holdQ.push_back(d);
  endtask

  // Single TX_LOAD strobe timed to coincide with the target acting on the SCK fall just driven
  task automatic pulseLoad(input logic [7:0] d);
    repeat (SYNC_STAGES) @(posedge CLKOSC);
    @(negedge CLKOSC);
    TX_DATA = d;
    TX_LOAD = 1'b1;
    @(negedge CLKOSC);
    TX_LOAD = 1'b0;
  endtask

  task automatic loadTx(input logic [7:0] d);
    @(negedge CLKOSC);
    checkOutput("tx_ready_before_load", 32'(TX_READY), 32'(holdQ.size() == 0));
    TX_DATA = d;
    TX_LOAD = 1'b1;
    modelLoad(d);
    @(negedge CLKOSC);
    TX_LOAD = 1'b0;
  endtask

  task automatic ackRx();
    @(negedge CLKOSC);
    RX_ACK = 1'b1;
    @(negedge CLKOSC);
    RX_ACK = 1'b0;
    mdlRxValid = 1'b0;
    checkOutput("rx_valid_after_ack", 32'(RX_VALID), 32'(0));
  endtask

  // One chip-select frame of nbits bits; the last SCK fall coincides with CS_N rising.
  task automatic applyStimulus(input int nbits, input logic [31:0] mosiWord,
                               input int loadBitA, input logic [7:0] loadDataA,
                               input int loadBitB, input logic [7:0] loadDataB);
    logic [7:0] rxByte;
    logic       expReadyA;
    logic       expReadyB;
    rxByte       = 8'h00;
    expReadyA    = 1'b1;
    expReadyB    = 1'b1;
    mdlByteIdx   = 0;
    mdlFullBytes = nbits / 8;
    modelStartByte();
    for (int i = 0; i < nbits; i++) begin
      rxByte = {rxByte[6:0], mosiWord[31-i]};
      if (i % 8 == 7) modelRxComplete(rxByte);
      if (i != nbits - 1) begin
        if (i % 8 == 7) modelStartByte();
        if (i == loadBitA) begin
          modelLoad(loadDataA);
          expReadyA = (holdQ.size() == 0);
        end
        if (i == loadBitB) begin
          modelLoad(loadDataB);
          expReadyB = (holdQ.size() == 0);
        end
      end
    end
    if (nbits % 8 != 0) pushEvent(EV_ABORT, 8'h00);

    @(negedge CLKOSC);
    CS_N = 1'b0;
    repeat (HALF) @(negedge CLKOSC);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosiWord[31-i];
      repeat (HALF) @(negedge CLKOSC);
      SCK = 1'b1;
      repeat (HALF) @(negedge CLKOSC);
      SCK = 1'b0;
      if (i == nbits - 1) begin
        CS_N = 1'b1;
      end else begin
        if (i == loadBitA) begin
          pulseLoad(loadDataA);
          checkOutput("tx_ready_after_load_a", 32'(TX_READY), 32'(expReadyA));
        end
        if (i == loadBitB) begin
          pulseLoad(loadDataB);
          checkOutput("tx_ready_after_load_b", 32'(TX_READY), 32'(expReadyB));
        end
      end
    end
    MOSI = 1'b1;
    repeat (2 * HALF) @(negedge CLKOSC);
    checkOutput("idle_miso_oe", 32'(MISO_OE), 32'(0));
    checkOutput("idle_miso", 32'(MISO), 32'(1));
    checkOutput("rx_data", 32'(RX_DATA), 32'(mdlRxLast));
    checkOutput("rx_valid", 32'(RX_VALID), 32'(mdlRxValid));
    checkOutput("tx_ready", 32'(TX_READY), 32'(holdQ.size() == 0));
  endtask

  // Event monitor: turns target pulses and fresh RX bytes into scoreboard pops.
  logic prevValid = 1'b0;
  always @(negedge CLKOSC) begin
    if (RX_OVERRUN) observeEvent(EV_RXOVR, RX_DATA);
    else if (RX_VALID && !prevValid) observeEvent(EV_RXNEW, RX_DATA);
    if (TX_UNDERRUN) observeEvent(EV_UNDER, 8'h00);
    if (FRAME_ABORT) observeEvent(EV_ABORT, 8'h00);
    prevValid = RX_VALID;
  end

  // MISO monitor: the initiator's view, sampling MISO on each SCK rise and checking whole bytes.
  int         misoBits = 0;
  logic [7:0] misoByte = 8'h00;
  always @(posedge SCK or posedge CS_N) begin
    if (CS_N || RST) begin
      misoBits = 0;
    end else begin
      misoByte = {misoByte[6:0], MISO};
      misoBits++;
      if (misoBits == 8) begin
        misoBits = 0;
        if (misoQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_miso_byte actual=%0h expected=none at %0t", misoByte, $time);
        end else begin
          checkOutput("miso_byte", 32'(misoByte), 32'(misoQ.pop_front()));
        end
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset behaviour, directed scenarios, then randomized frames.
  initial begin
    int         nbits;
    int         loadBit;
    logic [7:0] loadData;

    RST = 1'b1; SCK = 1'b0; MOSI = 1'b1; CS_N = 1'b0;
    RX_ACK = 1'b0; TX_DATA = 8'h00; TX_LOAD = 1'b0;

    for (int k = 0; k < 6; k++) begin
      repeat (2) @(negedge CLKOSC);
      SCK = ~SCK;
      checkOutput("reset_miso_oe", 32'(MISO_OE), 32'(0));
      checkOutput("reset_rx_valid", 32'(RX_VALID), 32'(0));
    end
    SCK  = 1'b0;
    CS_N = 1'b1;
    repeat (6) @(negedge CLKOSC);
    RST = 1'b0;
    repeat (2) @(negedge CLKOSC);
    checkOutput("reset_miso", 32'(MISO), 32'(1));
    checkOutput("reset_miso_oe_after", 32'(MISO_OE), 32'(0));
    checkOutput("reset_rx_data", 32'(RX_DATA), 32'(0));
    checkOutput("reset_rx_valid_after", 32'(RX_VALID), 32'(0));
    checkOutput("reset_tx_ready", 32'(TX_READY), 32'(1));

    $display("[TB] basic byte exchange");
    loadTx(8'hA5);
    applyStimulus(8, 32'h3C00_0000, -1, 8'h00, -1, 8'h00);
    ackRx();

    $display("[TB] back-to-back bytes with one queued");
    loadTx(8'h81);
    applyStimulus(16, 32'h96C3_0000, -1, 8'h00, -1, 8'h00);

    $display("[TB] aborted frame");
    applyStimulus(5, 32'hA800_0000, -1, 8'h00, -1, 8'h00);
    ackRx();

    $display("[TB] initiator read");
    loadTx(8'h5A);
    applyStimulus(8, 32'hFFFF_FFFF, -1, 8'h00, -1, 8'h00);
    ackRx();

    $display("[TB] load ignored while holding full");
    loadTx(8'h44);
    loadTx(8'h55);
    applyStimulus(8, 32'h1200_0000, -1, 8'h00, -1, 8'h00);
    ackRx();

    $display("[TB] load on reload cycle");
    loadTx(8'h33);
    applyStimulus(24, 32'h0102_0300, 2, 8'h22, 7, 8'h11);
    ackRx();

    $display("[TB] randomized frames");
    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 3))
        0:       nbits = 8;
        1:       nbits = 16;
        2:       nbits = 24;
        default: nbits = $urandom_range(1, 23);
      endcase
      if ($urandom_range(0, 1) == 1) loadTx(8'($urandom));
      if ($urandom_range(0, 3) == 0) loadTx(8'($urandom));
      loadBit  = -1;
      loadData = 8'($urandom);
      if (nbits > 1 && $urandom_range(0, 1) == 1) begin
        if (nbits > 8 && $urandom_range(0, 1) == 1) loadBit = 7;
        else loadBit = $urandom_range(0, nbits - 2);
      end
      applyStimulus(nbits, $urandom, loadBit, loadData, -1, 8'h00);
      if ($urandom_range(0, 1) == 1) ackRx();
    end

    repeat (4 * HALF) @(negedge CLKOSC);
    checkOutput("leftover_events", 32'(evQ.size()), 32'(0));
    checkOutput("leftover_miso_bytes", 32'(misoQ.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
